// File: rtl/sift_pkg.sv
// Shared definitions for the SIFT scale-space pipeline: pixel widths, default
// frame geometry and the 9-to-8 bit saturating clamp used by the DoG stages.
package sift_pkg;

  localparam int PIX_W     = 8;
  localparam int DIFF_W    = 9;
  localparam int IMG_W_DEF = 640;
  localparam int IMG_H_DEF = 480;

  localparam logic signed [DIFF_W-1:0] DIFF_MAX = 9'sd127;
  localparam logic signed [DIFF_W-1:0] DIFF_MIN = -9'sd128;

  function automatic logic [PIX_W-1:0] clamp9to8(input logic signed [DIFF_W-1:0] d);
    logic [PIX_W-1:0] r;
    if (d > DIFF_MAX) begin
      r = 8'h7F;
    end else if (d < DIFF_MIN) begin
      r = 8'h80;
    end else begin
      r = d[PIX_W-1:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/pix_delay.sv
// Enabled shift register for aligning pixel streams between scales.
// DEPTH=0 is a combinational passthrough.
module pix_delay
  import sift_pkg::*;
#(
  parameter int DEPTH = 0,
  parameter int W     = PIX_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clk_en,
  input  logic [W-1:0] i_pix,
  output logic [W-1:0] o_pix
);

  generate
    if (DEPTH == 0) begin : g_pass
      logic w_unused;
      assign w_unused = &{1'b0, clk, rst, clk_en};
      assign o_pix = i_pix;
    end else begin : g_sr
      logic [W-1:0] r_sr [DEPTH];

      always_ff @(posedge clk) begin
        if (rst) begin
          for (int i = 0; i < DEPTH; i++) r_sr[i] <= '0;
        end else if (clk_en) begin
          r_sr[0] <= i_pix;
          for (int i = 1; i < DEPTH; i++) r_sr[i] <= r_sr[i-1];
        end
      end

      assign o_pix = r_sr[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/dog_subtract.sv
// Difference-of-Gaussians: aligns two Gaussian streams, subtracts with
// saturation, flags strong responses and tags each pixel with raster position.
module dog_subtract
  import sift_pkg::*;
#(
  parameter int IMG_W   = IMG_W_DEF,
  parameter int IMG_H   = IMG_H_DEF,
  parameter int UP_LAT  = 17,
  parameter int A_DELAY = 0,
  parameter int THRESH  = 8,
  parameter int XW      = 10,
  parameter int YW      = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clk_en,
  input  logic [PIX_W-1:0] din_a,
  input  logic [PIX_W-1:0] din_b,
  output logic [PIX_W-1:0] dout,
  output logic             dout_valid,
  output logic             above_thresh,
  output logic [XW-1:0]    x_out,
  output logic [YW-1:0]    y_out,
  output logic             frame_start,
  output logic             line_end
);

  localparam int PW = $clog2(UP_LAT + 3);
  localparam logic [PW-1:0] PRIME_LAST = PW'(UP_LAT + 1);
  localparam logic [PW-1:0] PRIME_MAX  = PW'(UP_LAT + 2);
  localparam logic [XW-1:0] X_LAST     = XW'(IMG_W - 1);
  localparam logic [YW-1:0] Y_LAST     = YW'(IMG_H - 1);
  localparam logic [DIFF_W-1:0] THR    = DIFF_W'(THRESH);

  logic [PIX_W-1:0]         w_a_dly;
  logic [PIX_W-1:0]         w_clamped;
  logic [DIFF_W-1:0]        w_cl9;
  logic [DIFF_W-1:0]        w_mag;
  logic                     w_above;
  logic                     w_out_en;

  logic signed [DIFF_W-1:0] r_diff;
  logic [PIX_W-1:0]         r_dout;
  logic                     r_above;
  logic                     r_valid;
  logic [PW-1:0]            r_prime;
  logic [XW-1:0]            r_x;
  logic [YW-1:0]            r_y;
  logic [XW-1:0]            r_x_out;
  logic [YW-1:0]            r_y_out;
  logic                     r_fs;
  logic                     r_le;

  pix_delay #(.DEPTH(A_DELAY), .W(PIX_W)) u_a_delay (
    .clk    (clk),
    .rst    (rst),
    .clk_en (clk_en),
    .i_pix  (din_a),
    .o_pix  (w_a_dly)
  );

  // Magnitude taken in 9 bits so that -128 maps to +128 without wrapping.
  always_comb begin
    w_clamped = clamp9to8(r_diff);
    w_cl9     = {w_clamped[PIX_W-1], w_clamped};
    w_mag     = w_cl9[DIFF_W-1] ? (~w_cl9 + 9'd1) : w_cl9;
    w_above   = (w_mag >= THR);
    w_out_en  = (r_prime >= PRIME_LAST);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_diff  <= '0;
      r_dout  <= '0;
      r_above <= 1'b0;
      r_valid <= 1'b0;
      r_prime <= '0;
      r_x     <= '0;
      r_y     <= '0;
      r_x_out <= '0;
      r_y_out <= '0;
      r_fs    <= 1'b0;
      r_le    <= 1'b0;
    end else if (clk_en) begin
      r_diff  <= $signed({w_a_dly[PIX_W-1], w_a_dly}) - $signed({din_b[PIX_W-1], din_b});
      r_dout  <= w_clamped;
      r_above <= w_above;
      if (r_prime != PRIME_MAX) r_prime <= r_prime + 1'b1;
      // Coordinates are registered alongside dout so every output is coherent.
      if (w_out_en) begin
        r_valid <= 1'b1;
        r_x_out <= r_x;
        r_y_out <= r_y;
        r_fs    <= (r_x == '0) && (r_y == '0);
        r_le    <= (r_x == X_LAST);
        if (r_x == X_LAST) begin
          r_x <= '0;
          r_y <= (r_y == Y_LAST) ? '0 : r_y + 1'b1;
        end else begin
          r_x <= r_x + 1'b1;
        end
      end
    end
  end

  assign dout         = r_dout;
  assign dout_valid   = r_valid;
  assign above_thresh = r_above;
  assign x_out        = r_x_out;
  assign y_out        = r_y_out;
  assign frame_start  = r_fs;
  assign line_end     = r_le;

endmodule

// File: tb/tb_dog_subtract.sv
// Directed bench for dog_subtract: priming, saturation, alignment, enable
// gating, raster wrap and mid-frame reset across three configurations.
module tb_dog_subtract;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // d0: default geometry, A_DELAY=0
  logic       rst0 = 1'b1, en0 = 1'b0;
  logic [7:0] a0 = '0, b0 = '0, dout0;
  logic       v0, at0, fs0, le0;
  logic [9:0] x0;
  logic [8:0] y0;

  // d1: A_DELAY=3
  logic       rst1 = 1'b1, en1 = 1'b0;
  logic [7:0] a1 = '0, b1 = '0, dout1;
  logic       v1, at1, fs1, le1;
  logic [9:0] x1;
  logic [8:0] y1;

  // d2: 4x3 raster
  logic       rst2 = 1'b1, en2 = 1'b0;
  logic [7:0] a2 = '0, b2 = '0, dout2;
  logic       v2, at2, fs2, le2;
  logic [9:0] x2;
  logic [8:0] y2;

  dog_subtract u_d0 (
    .clk(clk), .rst(rst0), .clk_en(en0), .din_a(a0), .din_b(b0),
    .dout(dout0), .dout_valid(v0), .above_thresh(at0),
    .x_out(x0), .y_out(y0), .frame_start(fs0), .line_end(le0)
  );

  dog_subtract #(.A_DELAY(3)) u_d1 (
    .clk(clk), .rst(rst1), .clk_en(en1), .din_a(a1), .din_b(b1),
    .dout(dout1), .dout_valid(v1), .above_thresh(at1),
    .x_out(x1), .y_out(y1), .frame_start(fs1), .line_end(le1)
  );

  dog_subtract #(.IMG_W(4), .IMG_H(3)) u_d2 (
    .clk(clk), .rst(rst2), .clk_en(en2), .din_a(a2), .din_b(b2),
    .dout(dout2), .dout_valid(v2), .above_thresh(at2),
    .x_out(x2), .y_out(y2), .frame_start(fs2), .line_end(le2)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] ref_clamp(input logic [7:0] a, input logic [7:0] b);
    int d;
    d = int'($signed(a)) - int'($signed(b));
    if (d > 127) d = 127;
    if (d < -128) d = -128;
    return d[7:0];
  endfunction

  function automatic int mag8(input logic [7:0] v);
    return v[7] ? (256 - int'(v)) : int'(v);
  endfunction

  logic [7:0] exp_q[$];

  initial begin
    logic [7:0] exp_dout;
    logic       exp_valid, exp_fs, exp_le;
    int         exp_x, exp_y, m_cnt, mx, my;

    // ---------------- reset state
    tick();
    chk("rst_dout", dout0, 0);
    chk("rst_valid", v0, 0);
    chk("rst_above", at0, 0);
    chk("rst_x", x0, 0);
    chk("rst_y", y0, 0);
    chk("rst_fs", fs0, 0);
    chk("rst_le", le0, 0);

    // ---------------- test 1: constant inputs, priming length
    rst0 = 1'b0; en0 = 1'b1; a0 = 8'h10; b0 = 8'h08;
    for (int e = 1; e <= 19; e++) begin
      tick();
      chk("t1_valid", v0, (e >= 19) ? 1 : 0);
    end
    chk("t1_dout", dout0, 8'h08);
    chk("t1_above", at0, 1);
    chk("t1_fs", fs0, 1);
    chk("t1_x", x0, 0);
    chk("t1_y", y0, 0);
    chk("t1_le", le0, 0);

    // ---------------- test 2: saturation and threshold boundaries
    a0 = 8'h7F; b0 = 8'h80; tick(); tick();
    chk("t2_pos_sat", dout0, 8'h7F);
    chk("t2_pos_above", at0, 1);
    a0 = 8'h80; b0 = 8'h7F; tick(); tick();
    chk("t2_neg_sat", dout0, 8'h80);
    chk("t2_neg_above", at0, 1);
    a0 = 8'h05; b0 = 8'h00; tick(); tick();
    chk("t2_small", dout0, 8'h05);
    chk("t2_small_above", at0, 0);
    a0 = 8'h00; b0 = 8'h08; tick(); tick();
    chk("t2_neg8", dout0, 8'hF8);
    chk("t2_neg8_above", at0, 1);
    a0 = 8'h07; b0 = 8'h00; tick(); tick();
    chk("t2_seven_above", at0, 0);

    // ---------------- test 4: enable gating against a reference scoreboard
    rst0 = 1'b1; en0 = 1'b0; tick(); rst0 = 1'b0;
    exp_q.delete();
    exp_q.push_back(8'h00);
    exp_dout = 8'h00; exp_valid = 0; exp_fs = 0; exp_le = 0;
    exp_x = 0; exp_y = 0; m_cnt = 0; mx = 0; my = 0;
    for (int c = 0; c < 160; c++) begin
      en0 = 1'($urandom_range(0, 1));
      a0  = 8'($urandom_range(0, 255));
      b0  = 8'($urandom_range(0, 255));
      tick();
      if (en0) begin
        exp_q.push_back(ref_clamp(a0, b0));
        exp_dout = exp_q.pop_front();
        if (m_cnt >= 18) begin
          exp_valid = 1;
          exp_x = mx; exp_y = my;
          exp_fs = (mx == 0) && (my == 0);
          exp_le = (mx == 639);
          mx = (mx == 639) ? 0 : mx + 1;
        end
        if (m_cnt < 19) m_cnt++;
      end
      chk("t4_dout", dout0, exp_dout);
      chk("t4_above", at0, (mag8(exp_dout) >= 8) ? 1 : 0);
      chk("t4_valid", v0, exp_valid);
      chk("t4_x", x0, exp_x);
      chk("t4_y", y0, exp_y);
      chk("t4_fs", fs0, exp_fs);
      chk("t4_le", le0, exp_le);
    end
    en0 = 1'b0;

    // ---------------- test 3: A_DELAY=3 alignment of a ramp
    tick(); rst1 = 1'b0; en1 = 1'b1;
    for (int k = 0; k < 280; k++) begin
      a1 = 8'(k);
      b1 = (k >= 3) ? 8'(k - 3) : 8'h00;
      tick();
      if (k == 17) chk("t3_valid_lo", v1, 0);
      if (k >= 18) begin
        chk("t3_valid", v1, 1);
        chk("t3_dout", dout1, 0);
        chk("t3_above", at1, 0);
      end
    end
    en1 = 1'b0;

    // ---------------- test 5: 4x3 raster wrap
    rst2 = 1'b0; en2 = 1'b1;
    for (int e = 0; e < 18; e++) tick();
    chk("t5_valid_lo", v2, 0);
    for (int n = 1; n <= 19; n++) begin
      tick();
      chk("t5_valid", v2, 1);
      chk("t5_x", x2, (n - 1) % 4);
      chk("t5_y", y2, ((n - 1) / 4) % 3);
      chk("t5_le", le2, (n % 4 == 0) ? 1 : 0);
      chk("t5_fs", fs2, ((n - 1) % 12 == 0) ? 1 : 0);
    end
    chk("t5_pre_rst_x", x2, 2);
    chk("t5_pre_rst_y", y2, 1);

    // ---------------- test 6: mid-frame reset at (2,1)
    rst2 = 1'b1; tick(); rst2 = 1'b0;
    chk("t6_dout", dout2, 0);
    chk("t6_valid", v2, 0);
    chk("t6_above", at2, 0);
    chk("t6_x", x2, 0);
    chk("t6_y", y2, 0);
    chk("t6_fs", fs2, 0);
    chk("t6_le", le2, 0);
    for (int e = 1; e <= 18; e++) tick();
    chk("t6_valid_lo", v2, 0);
    tick();
    chk("t6_valid_hi", v2, 1);
    chk("t6_first_x", x2, 0);
    chk("t6_first_y", y2, 0);
    chk("t6_first_fs", fs2, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/dog_subtract.md
Name: dog_subtract

Overview:
- Difference-of-Gaussians stage directly downstream of two GAUSSIAN instances at adjacent scales.
- Inputs are two 8-bit two's-complement pixel streams, already offset by -128 upstream.
- Aligns the two streams, subtracts them with saturation, and flags strong responses.
- Emits the DoG pixel with valid, raster coordinates and frame/line markers for the extrema-detection stage.

Parameters:
- IMG_W, 640, pixels per line.
- IMG_H, 480, lines per frame.
- UP_LAT, 17, enabled-cycle latency of the din_b (larger-sigma) Gaussian path.
- A_DELAY, 0, extra enabled-cycle delay applied to din_a to align it with din_b. Legal range 0..32; must be <= UP_LAT.
- THRESH, 8, magnitude threshold for above_thresh (1..128).
- XW, 10, x coordinate width.
- YW, 9, y coordinate width.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- clk_en  in  1  pipeline advance enable, shared with the upstream GAUSSIAN blocks.
- din_a  in  8  smaller-sigma Gaussian pixel, signed.
- din_b  in  8  larger-sigma Gaussian pixel, signed.
- dout  out  8  saturated din_a - din_b, signed.
- dout_valid  out  1  dout is a real pixel, past the priming phase.
- above_thresh  out  1  |dout| >= THRESH, qualified by dout_valid.
- x_out  out  XW  column of dout.
- y_out  out  YW  row of dout.
- frame_start  out  1  dout_valid && x_out==0 && y_out==0.
- line_end  out  1  dout_valid && x_out==IMG_W-1.

Behaviour:
- Single clock domain: clk. rst is synchronous, active-high, and overrides clk_en.
- Reset values: all outputs 0; delay line, pipeline registers, prime counter and x/y counters cleared.
- State advances only on rising edges with clk_en=1 ("enabled edges"). With clk_en=0, every register and output holds.
- Alignment: din_a passes through an A_DELAY-deep enabled shift register; A_DELAY=0 is a straight wire. The din_b sampled at enabled edge k pairs with the din_a sampled at enabled edge k-A_DELAY.
- Stage 1, edge k: diff9 <= sext(a_dly) - sext(din_b). 9-bit signed, range -255..255.
- Stage 2, edge k+1:
  - dout <= clamp(diff9, -128, 127).
  - above_thresh <= (|clamped| >= THRESH), where |-128| = 128, computed in 9 bits.
- Latency: 2 enabled edges from din_b capture to dout.
- Priming:
  - A saturating counter counts enabled edges after reset, up to UP_LAT+2.
  - The first valid din_b is captured at enabled edge index UP_LAT (0-based).
  - dout_valid rises after edge UP_LAT+1, i.e. after the (UP_LAT+2)th enabled edge; with UP_LAT=17, after the 19th.
  - Once high, dout_valid stays high until reset.
  - While dout_valid=0, dout and above_thresh are still computed, but downstream ignores them.
- Raster counters:
  - Advance on each enabled edge that produces a valid output; the first valid output carries (0,0).
  - x wraps from IMG_W-1 to 0, and y increments on that wrap.
  - y wraps from IMG_H-1 to 0 when x also wraps (simultaneous wrap yields (0,0)).
  - frame_start, line_end, x_out and y_out are registered together with dout so all are coherent.
- Reset mid-frame: everything returns to the reset state on the next edge. A full UP_LAT+2 priming is required again, and coordinates restart at (0,0).

Decomposition:
- Shared package sift_pkg holds:
  - PIX_W=8 and DIFF_W=9.
  - Default IMG_W and IMG_H.
  - The saturating clamp function for 9-bit to 8-bit signed, reused by later DoG/extrema stages.
- One sub-module, pix_delay:
  - Parameterised-depth, PIX_W-wide shift register with clk_en and synchronous reset.
  - Depth 0 means passthrough.
  - Reusable for other scale-alignment points.

Test Plan:
1. Constant inputs: A_DELAY=0, UP_LAT=17, clk_en=1, din_a=8'h10, din_b=8'h08 from reset. Expect dout_valid=0 through the 18th edge and 1 after the 19th; dout=8'h08; above_thresh=1; first output frame_start=1 at (0,0).
2. Saturation:
   - din_a=8'h7F, din_b=8'h80: dout=8'h7F.
   - din_a=8'h80, din_b=8'h7F: dout=8'h80, above_thresh=1.
   - din_a=8'h05, din_b=8'h00: dout=8'h05, above_thresh=0.
3. Alignment: A_DELAY=3, din_a = ramp 0,1,2,…; din_b = the same ramp delayed 3 enabled cycles. After priming, dout=0 and above_thresh=0 on every valid cycle.
4. Enable gating: random clk_en with about 50% duty and a random pixel stream. The sequence of (dout, x_out, y_out, flags) sampled on enabled edges equals that of a clk_en=1 run; all outputs hold on disabled edges.
5. Raster wrap: IMG_W=4, IMG_H=3.
   - line_end on valid outputs 4, 8, 12 and 16.
   - frame_start on outputs 1 and 13.
   - Output 12 is at (3,2), and output 13 wraps to (0,0).
6. Mid-frame reset: assert rst for 1 cycle at x=2, y=1. Next cycle all outputs are 0. dout_valid returns only after another 19 enabled edges, with the first output at (0,0).
